// File: rtl/speck_out_buffer.sv
// Output buffer for the Speck-64 datapath: queues 64-bit blocks and drains each
// as two 32-bit words (low word first, high word flagged last).
module speck_out_buffer #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic [63:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [31:0] dout,
  output logic        dout_valid,
  output logic        dout_last,
  input  logic        dout_ready,
  output logic [AW:0] count
);

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;
  logic          r_half;

  logic          w_push;
  logic          w_xfer;
  logic          w_pop;
  logic [63:0]   w_head;

  // A full buffer refuses input even if the head block drains this same cycle.
  assign din_ready  = (r_cnt != FULL) && reset;
  assign dout_valid = (r_cnt != '0);
  assign w_head     = r_mem[r_rp];
  assign dout       = r_half ? w_head[63:32] : w_head[31:0];
  assign dout_last  = dout_valid && r_half;
  assign count      = r_cnt;

  assign w_push = din_valid && din_ready;
  assign w_xfer = dout_valid && dout_ready;
  assign w_pop  = w_xfer && r_half;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (clr) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_xfer) r_half <= ~r_half;
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (!clr && w_push) begin
      r_mem[r_wp] <= din;
    end
  end

endmodule

// File: tb/tb_speck_out_buffer.sv
// Scoreboard bench for speck_out_buffer: a word-level queue model predicts
// handshake state and the exact word stream the buffer must emit.
`timescale 1ns/1ps
module tb_speck_out_buffer;
  localparam int DEPTH = 2;
  localparam int AW    = 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_last;
  logic        dout_ready = 1'b0;
  logic [AW:0] count;

  speck_out_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset), .clr(clr), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_last(dout_last), .dout_ready(dout_ready), .count(count)
  );

  always #5 clk = ~clk;

  // Expected word stream: {last, word}; one block contributes two entries.
  logic [32:0] sb [$];
  int          checks = 0;
  int          errors = 0;
  logic        pend_push = 1'b0;
  logic        pend_clr  = 1'b0;
  logic [63:0] pend_d    = '0;
  int          accepted  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: any presented word must equal the scoreboard head (so a stalled
  // word is re-checked every cycle); a transfer retires it.
  always @(negedge clk) begin
    if (reset && dout_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", {31'b0, dout_last, dout}, 64'hDEAD);
      end else begin
        chk("dout_word", {32'b0, dout}, {32'b0, sb[0][31:0]});
        chk("dout_last", {63'b0, dout_last}, {63'b0, sb[0][32]});
        if (dout_ready) void'(sb.pop_front());
      end
    end
  end

  // One clock of stimulus; the model state is compared 3 ns after the edge.
  task automatic cycle(input logic v, input logic [63:0] d, input logic rdy, input logic c);
    int  held;
    logic exp_rdy;
    @(posedge clk);
    if (pend_clr) sb.delete();
    else if (pend_push) begin
      sb.push_back({1'b0, pend_d[31:0]});
      sb.push_back({1'b1, pend_d[63:32]});
    end
    #1;
    din_valid = v; din = d; dout_ready = rdy; clr = c;
    #2;
    held    = (sb.size() + 1) / 2;
    exp_rdy = (held < DEPTH);
    chk("din_ready",  {63'b0, din_ready},  {63'b0, exp_rdy});
    chk("count",      {62'b0, count},      64'(held));
    chk("dout_valid", {63'b0, dout_valid}, {63'b0, sb.size() != 0});
    pend_push = v && exp_rdy && !c;
    pend_clr  = c;
    pend_d    = d;
    if (pend_push) accepted++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_din_ready"},  {63'b0, din_ready},  64'd0);
    chk({tag, "_dout_valid"}, {63'b0, dout_valid}, 64'd0);
    chk({tag, "_dout_last"},  {63'b0, dout_last},  64'd0);
    chk({tag, "_dout"},       {32'b0, dout},       64'd0);
    chk({tag, "_count"},      {62'b0, count},      64'd0);
  endtask

  task automatic do_reset(input logic [63:0] d);
    @(posedge clk);
    #1;
    reset = 1'b0; din_valid = 1'b1; din = d; dout_ready = 1'b1; clr = 1'b0;
    sb.delete(); pend_push = 1'b0; pend_clr = 1'b0;
    #2;
    check_all_zero("rst");
    repeat (2) begin
      @(posedge clk); #3;
      check_all_zero("rst_hold");
    end
    @(posedge clk); #1;
    reset = 1'b1; din_valid = 1'b0;
    #2;
    chk("rst_release_ready", {63'b0, din_ready}, 64'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || pend_push) && n < 60) begin
      cycle(1'b0, '0, 1'b1, 1'b0);
      n++;
    end
    chk({tag, "_drained"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    logic [63:0] a, b, c, dblk;
    int          start;
    int          n;
    // Reset with din_valid asserted.
    din_valid = 1'b1; din = 64'hFFFF_0000_FFFF_0000; dout_ready = 1'b1;
    #3;
    check_all_zero("por");
    do_reset(64'h1111_2222_3333_4444);

    // Single block, known words.
    cycle(1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b0);
    drain("single");
    chk("single_count", {62'b0, count}, 64'd0);

    // Fill with backpressure: A, B accepted, C held until A.hi leaves.
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b0, 1'b0);
    cycle(1'b1, c, 1'b0, 1'b0);
    chk("fill_count", {62'b0, count}, 64'd2);
    start = accepted;
    n = 0;
    while (accepted == start && n < 20) begin
      cycle(1'b1, c, 1'b1, 1'b0);
      n++;
    end
    chk("fill_c_accepted", 64'(accepted - start), 64'd1);
    drain("fill");

    // Random stall: head words must stay stable while dout_ready toggles.
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      repeat (6) cycle(1'b0, '0, 1'($urandom_range(0, 1)), 1'b0);
    end
    drain("stall");

    // Streaming with random input gaps; pointers wrap several times.
    start = accepted;
    n = 0;
    while (accepted - start < 10 && n < 200) begin
      cycle(1'($urandom_range(0, 2) != 0), {$urandom, $urandom}, 1'b1, 1'b0);
      n++;
    end
    chk("stream_blocks", 64'(accepted - start), 64'd10);
    drain("stream");

    // Mixed random traffic including backpressure on both sides.
    repeat (60) cycle(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0), 1'b0);
    drain("mixed");

    // clr after the low word of A leaves; D offered in the clr cycle is dropped.
    a = {$urandom, $urandom}; dblk = {$urandom, $urandom};
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, dblk, 1'b1, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0);
    chk("clr_count", {62'b0, count}, 64'd0);
    chk("clr_valid", {63'b0, dout_valid}, 64'd0);
    cycle(1'b1, 64'hCAFEBABE_12345678, 1'b1, 1'b0);
    drain("after_clr");

    // Same scenario, using async reset instead of clr.
    a = {$urandom, $urandom};
    cycle(1'b1, a, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0);
    do_reset({$urandom, $urandom});
    cycle(1'b0, '0, 1'b0, 1'b0);
    cycle(1'b1, 64'hA5A5A5A5_5A5A5A5A, 1'b1, 1'b0);
    drain("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
